lfsr_chk: RTL and testbench

LFSR_CHK -- requirements
Module: lfsr_chk

---
 rtl/lfsr_chk.sv | 130 +++++++++++++
 tb/tb_lfsr_chk.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/lfsr_chk.sv
// PRBS checker for the 4-bit LFSR stream next = {q[2:0], q[3]^q[1]}.
// Hunts for alignment, flywheels in lock, and counts bit errors.
module lfsr_chk #(
  parameter int LOCK_CNT = 8,
  parameter int LOSS_CNT = 4,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_i,
  input  logic             bit_i,
  input  logic             clear_i,
  output logic             locked_o,
  output logic             err_o,
  output logic [CNT_W-1:0] err_cnt_o
);

  typedef enum logic [1:0] {
    FILL = 2'd0,
    HUNT = 2'd1,
    LOCK = 2'd2
  } st_t;

  localparam logic [7:0] LOCK_LAST = 8'(LOCK_CNT - 1);
  localparam logic [7:0] LOSS_LAST = 8'(LOSS_CNT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  st_t              st, st_n;
  logic [3:0]       sr, sr_n;
  logic [1:0]       fill, fill_n;
  logic [7:0]       mat, mat_n;
  logic [7:0]       mis, mis_n;
  logic             err_n;
  logic [CNT_W-1:0] cnt_n;
  logic             pred;
  logic             miss;

  assign pred = sr[3] ^ sr[1];
  assign miss = bit_i ^ pred;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st        <= FILL;
      sr        <= 4'h0;
      fill      <= 2'd0;
      mat       <= 8'd0;
      mis       <= 8'd0;
      locked_o  <= 1'b0;
      err_o     <= 1'b0;
      err_cnt_o <= '0;
    end else begin
      st        <= st_n;
      sr        <= sr_n;
      fill      <= fill_n;
      mat       <= mat_n;
      mis       <= mis_n;
      locked_o  <= (st_n == LOCK);
      err_o     <= err_n;
      err_cnt_o <= cnt_n;
    end
  end

  always_comb begin
    st_n   = st;
    sr_n   = sr;
    fill_n = fill;
    mat_n  = mat;
    mis_n  = mis;
    err_n  = 1'b0;
    if (valid_i) begin
      unique case (1'b1)
        (st == FILL): begin
          sr_n = {sr[2:0], bit_i};
          if (fill == 2'd3) begin
            fill_n = 2'd0;
            mat_n  = 8'd0;
            st_n   = HUNT;
          end else begin
            fill_n = fill + 2'd1;
          end
        end
        (st == HUNT): begin
          sr_n = {sr[2:0], bit_i};
          // an all-zero register is the LFSR lock-up state
          if (sr != 4'h0 && !miss) begin
            if (mat == LOCK_LAST) begin
              mat_n = 8'd0;
              mis_n = 8'd0;
              st_n  = LOCK;
            end else begin
              mat_n = mat + 8'd1;
            end
          end else begin
            mat_n = 8'd0;
          end
        end
        (st == LOCK): begin
          // flywheel: shift the prediction so one bad bit costs one error
          sr_n = {sr[2:0], pred};
          if (miss) begin
            err_n = 1'b1;
            if (mis == LOSS_LAST) begin
              mis_n  = 8'd0;
              mat_n  = 8'd0;
              fill_n = 2'd0;
              st_n   = FILL;
            end else begin
              mis_n = mis + 8'd1;
            end
          end else begin
            mis_n = 8'd0;
          end
        end
        default: begin
          st_n = FILL;
        end
      endcase
    end
  end

  always_comb begin
    cnt_n = err_cnt_o;
    if (clear_i) begin
      cnt_n = '0;
    end else if (err_n && err_cnt_o != CNT_MAX) begin
      cnt_n = err_cnt_o + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_lfsr_chk.sv
// Directed bench for lfsr_chk: expected outputs are queued per step
// and checked with immediate assertions after each clock edge.
module tb_lfsr_chk;

  logic       clk = 1'b0;
  logic       reset;
  logic       valid_i;
  logic       bit_i;
  logic       clear_i;
  logic       locked_o;
  logic       err_o;
  logic [3:0] err_cnt_o;

  int n_chk  = 0;
  int n_fail = 0;

  logic [3:0] gq;

  typedef struct {
    logic [5:0] v;
    string      tag;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  lfsr_chk #(
    .LOCK_CNT(8),
    .LOSS_CNT(4),
    .CNT_W   (4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .valid_i  (valid_i),
    .bit_i    (bit_i),
    .clear_i  (clear_i),
    .locked_o (locked_o),
    .err_o    (err_o),
    .err_cnt_o(err_cnt_o)
  );

  function automatic logic [5:0] ex(
    input logic l, input logic e, input int c
  );
    return {l, e, 4'(c)};
  endfunction

  task automatic check(input logic [5:0] exp, input string tag);
    logic [5:0] got;
    got = {locked_o, err_o, err_cnt_o};
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got lock/err/cnt %b/%b/%0d, want %b/%b/%0d",
             tag, got[5], got[4], got[3:0],
             exp[5], exp[4], exp[3:0]);
    end
  endtask

  task automatic step(
    input logic v, input logic b, input logic c,
    input logic [5:0] exp, input string tag
  );
    exp_t e;
    valid_i = v;
    bit_i   = b;
    clear_i = c;
    sb.push_back('{exp, tag});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check(e.v, e.tag);
  endtask

  task automatic nb(output logic b);
    b  = gq[0];
    gq = {gq[2:0], gq[3] ^ gq[1]};
  endtask

  initial begin
    logic b;
    reset   = 1'b0;
    valid_i = 1'b0;
    bit_i   = 1'b0;
    clear_i = 1'b0;
    #1;
    check(ex(0, 0, 0), "reset");
    repeat (2) @(posedge clk);
    #1;
    check(ex(0, 0, 0), "reset_hold");
    reset = 1'b1;
    step(0, 1, 0, ex(0, 0, 0), "post_release");

    gq = 4'b1000;
    for (int i = 1; i <= 12; i++) begin
      nb(b);
      step(1, b, 0, ex(i == 12, 0, 0), "lock");
    end

    nb(b);
    step(1, ~b, 0, ex(1, 1, 1), "err1");
    step(0, 0, 0, ex(1, 0, 1), "err1_idle");
    repeat (6) begin
      nb(b);
      step(1, b, 0, ex(1, 0, 1), "err1_after");
    end

    step(0, 0, 1, ex(1, 0, 0), "clr_idle");
    for (int i = 1; i <= 4; i++) begin
      nb(b);
      step(1, ~b, 0, ex(i < 4, 1, i), "loss");
    end
    for (int i = 1; i <= 12; i++) begin
      nb(b);
      step(1, b, 0, ex(i == 12, 0, 4), "relock");
    end

    step(0, 0, 1, ex(1, 0, 0), "clr_sat");
    for (int i = 1; i <= 20; i++) begin
      nb(b);
      step(1, ~b, 0, ex(1, 1, (i > 15) ? 15 : i), "sat");
      nb(b);
      step(1, b, 0, ex(1, 0, (i > 15) ? 15 : i), "sat_ok");
    end
    nb(b);
    step(1, ~b, 1, ex(1, 1, 0), "clr_wins");
    nb(b);
    step(1, b, 0, ex(1, 0, 0), "clr_after");

    reset = 1'b0;
    #1;
    check(ex(0, 0, 0), "rst_async");
    reset = 1'b1;
    for (int i = 1; i <= 100; i++) begin
      step(1, 0, 0, ex(0, 0, 0), "zeros");
    end

    reset = 1'b0;
    #1;
    reset = 1'b1;
    gq = 4'b1000;
    for (int i = 1; i <= 12; i++) begin
      nb(b);
      step(1, b, 0, ex(i == 12, 0, 0), "tog_valid");
      step(0, 1'($urandom), 0, ex(i == 12, 0, 0), "tog_idle");
    end
    nb(b);
    step(1, ~b, 0, ex(1, 1, 1), "pre_rst");
    #2;
    reset = 1'b0;
    #1;
    check(ex(0, 0, 0), "rst_mid");
    reset = 1'b1;
    step(0, 0, 0, ex(0, 0, 0), "rst_mid_hold");

    gq = 4'b1000;
    for (int i = 1; i <= 12; i++) begin
      nb(b);
      step(1, b, 0, ex(i == 12, 0, 0), "lock_after_rst");
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
